// File: rtl/cache_fill_ctrl_if.sv
// Bundle of cache-side and memory-side signals for cache_fill_ctrl.
// master = fill controller, slave = caches plus shared memory port.
//
// Handshake rules:
//   memory_req        : memory_address is a valid word request in this cycle.
//                       Memory accepts a request every cycle and never stalls.
//   memory_data_valid : memory_data holds one returned word in this cycle.
//                       Words come back in issue order, at least one cycle after
//                       their request.
//   miss_detected[i]  : level request from cache i. The cache holds it until it
//                       sees its own write_tag_array pulse.
interface cache_fill_ctrl_if #(
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 16,
   parameter int WORDS   = 8,
   parameter int NUM_REQ = 2
);
   localparam int IDX_W = $clog2(WORDS);

   logic [NUM_REQ-1:0]        miss_detected;
   logic [NUM_REQ*ADDR_W-1:0] miss_address;
   logic [NUM_REQ-1:0]        fsm_busy;
   logic                      memory_req;
   logic [ADDR_W-1:0]         memory_address;
   logic                      memory_data_valid;
   logic [DATA_W-1:0]         memory_data;
   logic [NUM_REQ-1:0]        write_data_array;
   logic [IDX_W-1:0]          fill_word_idx;
   logic [DATA_W-1:0]         fill_data;
   logic [NUM_REQ-1:0]        write_tag_array;
   logic [1:0]                dbg_state;   // FSM state: 0 idle, 1 fill, 2 commit

   modport master (
      input  miss_detected, miss_address, memory_data_valid, memory_data,
      output fsm_busy, memory_req, memory_address, write_data_array,
             fill_word_idx, fill_data, write_tag_array, dbg_state
   );

   modport slave (
      output miss_detected, miss_address, memory_data_valid, memory_data,
      input  fsm_busy, memory_req, memory_address, write_data_array,
             fill_word_idx, fill_data, write_tag_array, dbg_state
   );
endinterface

// File: rtl/cache_fill_ctrl.sv
// Multi-requester cache-block fill controller.
// Grants one missing cache at a time (round-robin), issues WORDS word requests
// on consecutive cycles, steers returned words into the owner's data array and
// finishes with a one-cycle tag write pulse.
// Optional feature macro: CACHE_FILL_CWF_EN (critical-word-first fill order).
module cache_fill_ctrl #(
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 16,
   parameter int WORDS   = 8,
   parameter int NUM_REQ = 2
) (
   input  logic clk,
   input  logic rst_n,
   cache_fill_ctrl_if.master io_bus
);
   localparam int IDX_W   = $clog2(WORDS);
   localparam int CNT_W   = IDX_W + 1;
   localparam int BYTE_SH = $clog2(DATA_W / 8);
   localparam int OFF_W   = IDX_W + BYTE_SH;
   localparam int OWN_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   localparam logic [CNT_W-1:0]  WORDS_C  = CNT_W'(WORDS);
   localparam logic [CNT_W-1:0]  LAST_C   = CNT_W'(WORDS - 1);
   localparam logic [OWN_W-1:0]  OWN_LAST = OWN_W'(NUM_REQ - 1);
   localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((1 << OFF_W) - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_FILL   = 2'd1,
      ST_COMMIT = 2'd2
   } state_t;

   state_t            r_state;
   logic [CNT_W-1:0]  r_issued;
   logic [CNT_W-1:0]  r_received;
   logic [OWN_W-1:0]  r_owner;
   logic [OWN_W-1:0]  r_ptr;
   logic [ADDR_W-1:0] r_base;
   logic [IDX_W-1:0]  r_crit;
   logic              r_mem_req;
   logic [ADDR_W-1:0] r_mem_addr;

   logic [ADDR_W-1:0]  w_miss_addr [NUM_REQ];
   logic               w_grant_found;
   logic [OWN_W-1:0]   w_grant_idx;
   logic [OWN_W-1:0]   w_cand;
   logic [ADDR_W-1:0]  w_grant_addr;
   logic [ADDR_W-1:0]  w_grant_base;
   logic [IDX_W-1:0]   w_grant_crit;
   logic [CNT_W-1:0]   w_issued_nx;
   logic [IDX_W-1:0]   w_next_slot;
   logic               w_beat;
   logic [NUM_REQ-1:0] w_owner_oh;
   logic [NUM_REQ-1:0] w_busy;

   // Word address of block slot 'slot'; wraps modulo 2^ADDR_W.
   function automatic logic [ADDR_W-1:0] f_word_addr(input logic [ADDR_W-1:0] base,
                                                    input logic [IDX_W-1:0]  slot);
      return base + (ADDR_W'(slot) << BYTE_SH);
   endfunction

   // Split the flat miss address bus into one address per requester.
   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         w_miss_addr[i] = io_bus.miss_address[i*ADDR_W +: ADDR_W];
      end
   end

   // Round-robin pick: first pending miss at or after the pointer.
   always_comb begin
      w_grant_found = 1'b0;
      w_grant_idx   = '0;
      w_cand        = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         w_cand = OWN_W'((int'(r_ptr) + k) % NUM_REQ);
         if (!w_grant_found && io_bus.miss_detected[w_cand]) begin
            w_grant_found = 1'b1;
            w_grant_idx   = w_cand;
         end
      end
   end

   assign w_grant_addr = w_miss_addr[w_grant_idx];
   assign w_grant_base = w_grant_addr & ~OFF_MASK;

`ifdef CACHE_FILL_CWF_EN
   // Start the fill at the word that actually missed.
   assign w_grant_crit = IDX_W'((w_grant_addr & OFF_MASK) >> BYTE_SH);
`else
   assign w_grant_crit = '0;
`endif

   assign w_issued_nx = r_issued + CNT_W'(1);
   assign w_next_slot = r_crit + w_issued_nx[IDX_W-1:0];

   // A returned word is only accepted while the block is still incomplete.
   assign w_beat     = (r_state == ST_FILL) && io_bus.memory_data_valid && (r_received < WORDS_C);
   assign w_owner_oh = NUM_REQ'(1) << r_owner;

   // Single FSM: grant, issue/collect words, commit tag; request outputs registered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_issued   <= '0;
         r_received <= '0;
         r_owner    <= '0;
         r_ptr      <= '0;
         r_base     <= '0;
         r_crit     <= '0;
         r_mem_req  <= 1'b0;
         r_mem_addr <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_grant_found) begin
                  r_owner    <= w_grant_idx;
                  r_base     <= w_grant_base;
                  r_crit     <= w_grant_crit;
                  r_issued   <= '0;
                  r_received <= '0;
                  r_mem_req  <= 1'b1;
                  r_mem_addr <= f_word_addr(w_grant_base, w_grant_crit);
                  r_state    <= ST_FILL;
               end
            end
            ST_FILL: begin
               if (r_issued < WORDS_C) begin
                  r_issued <= w_issued_nx;
                  if (w_issued_nx < WORDS_C) begin
                     r_mem_addr <= f_word_addr(r_base, w_next_slot);
                  end else begin
                     r_mem_req  <= 1'b0;
                     r_mem_addr <= '0;
                  end
               end
               if (w_beat) begin
                  r_received <= r_received + CNT_W'(1);
                  if (r_received == LAST_C) begin
                     r_state <= ST_COMMIT;
                  end
               end
            end
            ST_COMMIT: begin
               r_ptr   <= (r_owner == OWN_LAST) ? '0 : r_owner + OWN_W'(1);
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // Stall: a cache is busy while it misses or while its fill is in flight.
   // Gated by reset so every output reads 0 while rst_n is low.
   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         w_busy[i] = rst_n & (io_bus.miss_detected[i] |
                              ((r_state != ST_IDLE) && (r_owner == OWN_W'(i))));
      end
   end

   // Write strobes follow memory_data_valid in the same cycle so they line up
   // with the combinational fill_data pass-through.
   assign io_bus.fsm_busy         = w_busy;
   assign io_bus.memory_req       = r_mem_req;
   assign io_bus.memory_address   = r_mem_addr;
   assign io_bus.write_data_array = w_beat ? w_owner_oh : '0;
   assign io_bus.fill_word_idx    = w_beat ? (r_crit + r_received[IDX_W-1:0]) : '0;
   assign io_bus.fill_data        = rst_n ? io_bus.memory_data : '0;
   assign io_bus.write_tag_array  = (r_state == ST_COMMIT) ? w_owner_oh : '0;
   assign io_bus.dbg_state        = r_state;
endmodule
